wb_merge: RTL

Writeback merge stage sitting directly upstream of the register file's write port. Each cycle it takes at most one single-cycle result from the main pipeline's MEM/WB latch and buffers results from a multi-cycle auxiliary unit (mul/div) in a small FIFO. It drives a registered `regwrite`/`wrreg`/`wrdata` triple into the register file and flags register addresses that still have a queued write, so decode can stall.

---
 rtl/wb_merge.sv | 123 ++++++++++++
 1 files changed

// File: rtl/wb_merge.sv
// Writeback merge stage: single-cycle pipeline results bypass a small aux FIFO,
// which drains into the registered register-file write port when the pipeline is idle.
// Optional macro: WB_SQUASH_EN -- a pipeline write invalidates queued aux writes to the same register.
module wb_merge #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_wrreg,
  input  logic [31:0] pipe_wrdata,
  input  logic        aux_valid,
  output logic        aux_ready,
  input  logic [4:0]  aux_wrreg,
  input  logic [31:0] aux_wrdata,
  input  logic [4:0]  chk1,
  input  logic [4:0]  chk2,
  input  logic [4:0]  chk3,
  output logic        pend1,
  output logic        pend2,
  output logic        pend3,
  output logic        regwrite,
  output logic [4:0]  wrreg,
  output logic [31:0] wrdata
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] valid_nxt;
  logic [4:0]       ent_reg  [DEPTH];
  logic [31:0]      ent_data [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;

  logic pipe_hit;
  logic push;
  logic pop;

  // Ready depends only on occupancy so upstream never sees a drain-dependent path.
  assign aux_ready = (count != CW'(DEPTH));
  assign pipe_hit  = pipe_we && (pipe_wrreg != 5'd0);
  assign push      = aux_valid && aux_ready && (aux_wrreg != 5'd0);
  assign pop       = !pipe_hit && (count != CW'(0));

  // Next valid bits: popped slot freed, optional squash, then the newly pushed slot.
  always_comb begin
    valid_nxt = ent_valid;
    if (pop) valid_nxt[rd_ptr] = 1'b0;
`ifdef WB_SQUASH_EN
    if (pipe_hit) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (ent_reg[i] == pipe_wrreg) valid_nxt[i] = 1'b0;
      end
    end
`endif
    if (push) valid_nxt[wr_ptr] = 1'b1;
  end

  // FIFO control state: pointers, occupancy and per-entry valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_valid <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
    end else begin
      ent_valid <= valid_nxt;
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO payload storage; contents are only meaningful while the valid bit is set.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_reg[wr_ptr]  <= aux_wrreg;
      ent_data[wr_ptr] <= aux_wrdata;
    end
  end

  // Registered write port: pipeline first, else the FIFO head; address/data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwrite <= 1'b0;
      wrreg    <= 5'd0;
      wrdata   <= 32'd0;
    end else if (pipe_hit) begin
      regwrite <= 1'b1;
      wrreg    <= pipe_wrreg;
      wrdata   <= pipe_wrdata;
    end else if (pop && ent_valid[rd_ptr]) begin
      regwrite <= 1'b1;
      wrreg    <= ent_reg[rd_ptr];
      wrdata   <= ent_data[rd_ptr];
    end else begin
      regwrite <= 1'b0;
    end
  end

  // Pending flags over queued entries only; the output register is bypassed by the regfile.
  always_comb begin
    pend1 = 1'b0;
    pend2 = 1'b0;
    pend3 = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (ent_valid[i] && (ent_reg[i] == chk1)) pend1 = 1'b1;
      if (ent_valid[i] && (ent_reg[i] == chk2)) pend2 = 1'b1;
      if (ent_valid[i] && (ent_reg[i] == chk3)) pend3 = 1'b1;
    end
    if (chk1 == 5'd0) pend1 = 1'b0;
    if (chk2 == 5'd0) pend2 = 1'b0;
    if (chk3 == 5'd0) pend3 = 1'b0;
  end

endmodule
